// File: rtl/alarm_pkg.sv
// Shared types for the alarm clock time-set path.
package alarm_pkg;

    localparam int SPEED_W = $clog2(1000000) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOW = 2'd1,
        MED  = 2'd2,
        FAST = 2'd3
    } ramp_state_t;

endpackage

// File: rtl/tick_edge_detect.sv
// Registers a clk-synchronous tick and flags its rising edge in the current cycle.
module tick_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    output logic rise_o
);

    logic tick_q;

    always_ff @(posedge clk) begin
        if (reset) tick_q <= 1'b0;
        else       tick_q <= tick_i;
    end

    assign rise_o = tick_i & ~tick_q;

endmodule

// File: rtl/speed_ramp_ctrl.sv
// Time-set divider arbiter: grants one set button, ramps divider speed while held,
// and converts divider edges into increment pulses.
//   state | meaning
//   IDLE  | no owner, divider at IDLE_HZ, round-robin arbitration
//   SLOW  | owner holding, SLOW_HZ
//   MED   | owner held one step, MED_HZ
//   FAST  | owner held two steps, FAST_HZ (saturates)
module speed_ramp_ctrl
    import alarm_pkg::*;
#(
    parameter int BASE_SPEED  = 50000000,
    parameter int STEP_CYCLES = 100000000,
    parameter int IDLE_HZ     = 1,
    parameter int SLOW_HZ     = 2,
    parameter int MED_HZ      = 8,
    parameter int FAST_HZ     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req,
    input  logic               div_tick,
    output logic [SPEED_W-1:0] speed,
    output logic               div_reset,
    output logic [1:0]         grant,
    output logic [1:0]         inc
);

    localparam int HOLD_W = $clog2(STEP_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STEP_CYCLES - 1);

    if (BASE_SPEED < 1 || STEP_CYCLES < 2) begin : g_bad_timing
        $error("speed_ramp_ctrl: invalid BASE_SPEED or STEP_CYCLES");
    end
    if (IDLE_HZ < 1 || SLOW_HZ < 1 || MED_HZ < 1 || FAST_HZ < 1 ||
        IDLE_HZ > 1000000 || SLOW_HZ > 1000000 || MED_HZ > 1000000 || FAST_HZ > 1000000) begin : g_bad_speed
        $error("speed_ramp_ctrl: speed parameter out of range");
    end

    ramp_state_t        state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               rr_q, rr_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               div_reset_q, div_reset_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         inc_q, inc_d;
    logic               tick_rise;
    logic               win_bit;

    tick_edge_detect u_tick_edge (
        .clk    (clk),
        .reset  (reset),
        .tick_i (div_tick),
        .rise_o (tick_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            rr_q        <= 1'b0;
            speed_q     <= SPEED_W'(IDLE_HZ);
            div_reset_q <= 1'b0;
            grant_q     <= 2'b00;
            inc_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            rr_q        <= rr_d;
            speed_q     <= speed_d;
            div_reset_q <= div_reset_d;
            grant_q     <= grant_d;
            inc_q       <= inc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        rr_d        = rr_q;
        speed_d     = speed_q;
        div_reset_d = 1'b0;
        grant_d     = grant_q;
        inc_d       = 2'b00;
        win_bit     = (req == 2'b11) ? rr_q : req[1];

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d     = SLOW;
                    hold_d      = '0;
                    speed_d     = SPEED_W'(SLOW_HZ);
                    div_reset_d = 1'b1;
                    grant_d     = win_bit ? 2'b10 : 2'b01;
                    inc_d       = win_bit ? 2'b10 : 2'b01;
                end
            end
            default: begin
                if ((req & grant_q) == 2'b00) begin
                    // Release beats both a step boundary and a coincident tick edge.
                    state_d     = IDLE;
                    hold_d      = '0;
                    speed_d     = SPEED_W'(IDLE_HZ);
                    div_reset_d = 1'b1;
                    grant_d     = 2'b00;
                    rr_d        = grant_q[0];
                end else begin
                    if (tick_rise && !div_reset_q) inc_d = grant_q;
                    if (state_q == FAST) begin
                        hold_d = '0;
                    end else if (hold_q == HOLD_LAST) begin
                        hold_d      = '0;
                        div_reset_d = 1'b1;
                        if (state_q == SLOW) begin
                            state_d = MED;
                            speed_d = SPEED_W'(MED_HZ);
                        end else begin
                            state_d = FAST;
                            speed_d = SPEED_W'(FAST_HZ);
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
        endcase
    end

    assign speed     = speed_q;
    assign div_reset = div_reset_q;
    assign grant     = grant_q;
    assign inc       = inc_q;

endmodule

// File: tb/tb_speed_ramp_ctrl.sv
// Self-checking bench for speed_ramp_ctrl: directed scenarios then random
// request/tick traffic, all compared each cycle against an ownership-time model.
module tb_speed_ramp_ctrl;
    import alarm_pkg::*;

    localparam int STEP = 10;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         req;
    logic               div_tick;
    logic [SPEED_W-1:0] speed;
    logic               div_reset;
    logic [1:0]         grant;
    logic [1:0]         inc;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: owner (-1 = none), cycles since grant, rr pointer.
    int       m_own = -1;
    int       m_k = 0;
    int       m_ptr = 0;
    bit       m_prev_tick = 0;
    bit [1:0] e_grant = 0;
    bit [1:0] e_inc = 0;
    bit       e_dr = 0;
    int       e_speed = 1;

    speed_ramp_ctrl #(
        .STEP_CYCLES (STEP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .div_tick  (div_tick),
        .speed     (speed),
        .div_reset (div_reset),
        .grant     (grant),
        .inc       (inc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit [1:0] r, input bit t, input bit rs);
        bit rise;
        int lvl;
        if (rs) begin
            m_own = -1; m_k = 0; m_ptr = 0; m_prev_tick = 0;
            e_grant = 0; e_inc = 0; e_dr = 0; e_speed = 1;
            return;
        end
        rise = t && !m_prev_tick;
        m_prev_tick = t;
        if (m_own < 0) begin
            e_inc = 0;
            e_dr = 0;
            if (r != 0) begin
                m_own = (r == 2'b11) ? m_ptr : ((r == 2'b10) ? 1 : 0);
                m_k = 0;
                e_grant = 2'(1 << m_own);
                e_inc = e_grant;
                e_speed = 2;
                e_dr = 1;
            end
        end else if (!r[m_own]) begin
            m_ptr = 1 - m_own;
            m_own = -1;
            e_grant = 0;
            e_inc = 0;
            e_speed = 1;
            e_dr = 1;
        end else begin
            e_inc = (rise && !e_dr) ? e_grant : 2'b00;
            m_k++;
            lvl = (m_k / STEP > 2) ? 2 : m_k / STEP;
            e_speed = (lvl == 0) ? 2 : ((lvl == 1) ? 8 : 32);
            e_dr = (m_k == STEP) || (m_k == 2 * STEP);
        end
    endtask

    task automatic cyc(input logic [1:0] r, input logic t, input logic rs);
        req = r;
        div_tick = t;
        reset = rs;
        @(posedge clk);
        #1;
        model_step(r, t, rs);
        check_val("grant", 32'(grant), 32'(e_grant));
        check_val("speed", 32'(speed), 32'(e_speed));
        check_val("div_reset", 32'(div_reset), 32'(e_dr));
        check_val("inc", 32'(inc), 32'(e_inc));
    endtask

    initial begin
        logic [1:0] r;
        logic       t;
        int         per;
        int         ph;

        cyc(2'b00, 1'b0, 1'b1);
        cyc(2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(2'b00, 1'b0, 1'b0);

        // Single request ramp through to FAST saturation.
        for (int i = 0; i < 35; i++) cyc(2'b01, 1'b0, 1'b0);
        check_val("fast_sat", 32'(speed), 32'd32);
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);

        // Arbitration and round-robin.
        cyc(2'b11, 1'b0, 1'b1);
        cyc(2'b11, 1'b0, 1'b0);
        check_val("arb_first", 32'(grant), 32'd1);
        cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 1'b0);
        check_val("arb_gap", 32'(grant), 32'd0);
        cyc(2'b10, 1'b0, 1'b0);
        check_val("arb_second", 32'(grant), 32'd2);
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);
        check_val("arb_rr", 32'(grant), 32'd1);

        // Tick square wave period 6 while granted, other bit also requesting.
        for (int i = 0; i < 40; i++) cyc(2'b11, ((i % 6) < 3) ? 1'b0 : 1'b1, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);

        // Release on the step-boundary cycle of SLOW.
        for (int i = 0; i < 10; i++) cyc(2'b01, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        check_val("collide_speed", 32'(speed), 32'd1);
        cyc(2'b00, 1'b0, 1'b0);

        // Release coincident with a tick edge.
        for (int i = 0; i < 4; i++) cyc(2'b10, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0);
        check_val("collide_inc", 32'(inc), 32'd0);
        cyc(2'b00, 1'b0, 1'b0);

        // Reset mid-FAST with request held.
        for (int i = 0; i < 25; i++) cyc(2'b01, 1'b0, 1'b0);
        cyc(2'b01, 1'b0, 1'b1);
        check_val("rst_dr", 32'(div_reset), 32'd0);
        cyc(2'b01, 1'b0, 1'b0);
        check_val("rst_regrant", 32'(grant), 32'd1);

        // Random traffic: sticky requests, variable-period ticks, rare resets.
        r = 2'b00;
        per = 6;
        ph = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) r[0] = ~r[0];
            if ($urandom_range(0, 24) == 0) r[1] = ~r[1];
            if ($urandom_range(0, 59) == 0) per = $urandom_range(2, 9);
            ph = (ph + 1) % per;
            t = (ph < per / 2) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 15) == 0) t = $urandom_range(0, 1);
            cyc(r, t, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/speed_ramp_ctrl.md
# speed_ramp_ctrl

Arbitrates the alarm clock's single "time-set" clock divider between two set-button requesters (hours, minutes) and configures the divider's speed. While a button is held, the speed ramps from slow to fast. Rising edges of the divider output become one-cycle increment pulses for the granted requester. The block sits between the debounced button logic and the time/alarm registers, and drives the divider's `speed` and `reset` inputs.

## Interface
Parameters:
- `BASE_SPEED`, default 50000000: system clock frequency in Hz. Informational; must match the divider.
- `STEP_CYCLES`, default 100000000: hold cycles per ramp step (2 s at 50 MHz). Must be ≥ 2.
- `IDLE_HZ`, default 1: speed driven when nothing is granted.
- `SLOW_HZ`, default 2: first ramp speed.
- `MED_HZ`, default 8: second ramp speed.
- `FAST_HZ`, default 32: third ramp speed. All speed values must be ≥ 1 and ≤ 1000000.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `req`, in, 2: level requests. Bit 0 = minute-set, bit 1 = hour-set. Already debounced and synchronous to `clk`.
- `div_tick`, in, 1: divider output clock, synchronous to `clk`.
- `speed`, out, SPEED_W (= $clog2(1000000)+1 = 21): divider speed in Hz.
- `div_reset`, out, 1: one-cycle pulse that makes the divider restart and load `speed`.
- `grant`, out, 2: one-hot or zero. Indicates the current owner.
- `inc`, out, 2: one-cycle increment pulse. Only the granted bit can ever be high.

## Operation
- All outputs are registered.
- Reset values: `speed`=IDLE_HZ, `div_reset`=0, `grant`=0, `inc`=0, state=IDLE, hold counter=0, round-robin pointer=0 (favours bit 0), tick history=0.
- **State machine:** IDLE → SLOW → MED → FAST. FAST saturates.
- **IDLE:**
  - A single set bit in `req` is granted.
  - If both bits are set, the bit selected by the round-robin pointer wins.
  - On a grant: state=SLOW, `speed`=SLOW_HZ, `div_reset`=1, `inc[g]`=1 (the immediate first increment), hold counter=0.
- **SLOW / MED:**
  - While `req[g]` stays high, the hold counter increments each cycle.
  - When the counter reaches STEP_CYCLES-1, it clears and the state advances. `speed` becomes MED_HZ or FAST_HZ, and `div_reset` pulses for one cycle.
- **FAST:** the hold counter stays at 0. No further speed changes occur.
- **Release:** `req[g]` low in any non-IDLE state causes, in the next cycle:
  - state=IDLE, `grant`=0, `speed`=IDLE_HZ, `div_reset`=1.
  - The pointer is set to the other requester.
- **Increment pulses:**
  - A rising edge of `div_tick` (current=1, previous=0) while granted raises `inc[g]` in the next cycle.
  - Edges are masked in any cycle where `div_reset` is high.
- The non-granted requester is ignored until return to IDLE. State stays IDLE for at least one cycle between grants.
- **Simultaneous events:**
  - Release and step boundary in the same cycle: release wins.
  - Release and `div_tick` edge in the same cycle: no `inc` is issued.
  - Both requests rise in the same cycle: the round-robin pointer decides.
- **Reset mid-operation:** all registers return to reset values on the next edge. No `div_reset` pulse is issued on exit from reset.

## Timing
- `req` rises in cycle n: `grant`, `speed`, `div_reset` and `inc` are valid in cycle n+1.
- `div_tick` edge sampled in cycle n: `inc` is high in cycle n+1 and low in n+2.
- Ramp step: the SLOW→MED change appears STEP_CYCLES cycles after grant. MED→FAST appears STEP_CYCLES cycles later.
- `req[g]` falls in cycle n: `grant`=0 in n+1. The earliest re-grant is at n+2.
- Hold counter width is $clog2(STEP_CYCLES). Comparison is an equality against STEP_CYCLES-1; the counter never wraps.

## Structure
- Shared package `alarm_pkg`:
  - `SPEED_W` constant.
  - `ramp_state_t` enum {IDLE, SLOW, MED, FAST}.
- One sub-module, `tick_edge_detect`: registers `div_tick` and outputs the rise condition. Reused by the time counters.
- The FSM, arbiter pointer and hold counter live in `speed_ramp_ctrl`.

## Test plan
All scenarios use STEP_CYCLES=10.
- **Reset, then idle:** `speed`=1, `grant`=0, `inc`=0, `div_reset`=0 for 20 cycles.
- **Single request:**
  - `req`=01 at cycle 5: cycle 6 shows `grant`=01, `speed`=2, `div_reset`=1, `inc`=01.
  - `speed`=8 at cycle 16 and 32 at cycle 26, each with one `div_reset` pulse.
  - `speed` stays 32 afterwards.
- **Arbitration:**
  - `req`=11 from reset: bit 0 is granted.
  - Drop bit 0: `grant`=00 for one cycle, then `grant`=10.
  - Drop bit 1 and reassert both: bit 0 is granted (round-robin).
- **Increment pulses:** drive a `div_tick` square wave of period 6 while granted. Expect exactly one `inc` per rising edge, one cycle after the edge, and none for the non-granted bit.
- **Collisions:**
  - Release on cycle 9 of SLOW: IDLE with `speed`=1, never 8.
  - Release coincident with a `div_tick` edge: no `inc`.
- **Reset mid-FAST:** assert `reset` for one cycle. All outputs return to reset values next cycle with no `div_reset` pulse; a held `req` is re-granted one cycle after reset deasserts.
